// File: rtl/fperm_pkg.sv
// Shared definitions for the FP permute/seed pipeline: tags, opcodes, stage record
// and exponent-field helpers for the double and single-pair word layouts.
package fperm_pkg;

  localparam logic [1:0] PTYPE_DBL  = 2'b01;
  localparam logic [1:0] PTYPE_SNGL = 2'b10;

  localparam int BIAS_D_DEF = 2047;
  localparam int BIAS_S_DEF = 255;

  typedef enum logic [2:0] {
    OP_MOV   = 3'd0,
    OP_SWAP  = 3'd1,
    OP_DUPLO = 3'd2,
    OP_DUPHI = 3'd3,
    OP_RCP   = 3'd4,
    OP_RSQ   = 3'd5,
    OP_BLEND = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef struct packed {
    logic [67:0] data;
    logic        vld;
    logic        err;
  } stage_t;

  // The exponent MSBs are scattered around the sign bit; these keep that in one place.
  function automatic logic [11:0] exp_get_dbl(input logic [67:0] w);
    return {w[63], w[65], w[62:53]};
  endfunction

  function automatic logic [67:0] exp_put_dbl(input logic [1:0] tag, input logic sign,
                                              input logic [11:0] e);
    return {tag, e[10], sign, e[11], e[9:0], 53'b0};
  endfunction

  // A 33-bit lane: hi lane is w[65:33], lo lane is w[32:0]; same internal layout.
  function automatic logic [8:0] exp_get_lane(input logic [32:0] l);
    return {l[30], l[32], l[29:23]};
  endfunction

  function automatic logic [32:0] exp_put_lane(input logic sign, input logic [8:0] e);
    return {e[7], sign, e[8], e[6:0], 23'b0};
  endfunction

endpackage

// File: rtl/fperm_exp_seed.sv
// Reciprocal / reciprocal-sqrt exponent seed for one exponent field (combinational).
module fperm_exp_seed #(
  parameter int EW   = 12,
  parameter int BIAS = 2047
) (
  input  logic [EW-1:0] e,
  input  logic          is_rsq,
  output logic [EW-1:0] e_seed
);

  localparam logic [EW+1:0] TWO_B   = (EW+2)'(2 * BIAS);
  localparam logic [EW+1:0] THREE_B = (EW+2)'(3 * BIAS);

  // RSQ halves after the subtraction, so it needs the two extra bits before truncating.
  assign e_seed = is_rsq ? EW'((THREE_B - {2'b00, e}) >> 1)
                         : EW'(TWO_B - {2'b00, e});

endmodule

// File: rtl/fperm_pipe.sv
// Pipelined FP permute/seed unit: lane moves, blend and exponent seeds behind a
// LAT-deep stall/flush pipeline.
module fperm_pipe
  import fperm_pkg::*;
#(
  parameter int LAT    = 2,
  parameter int BIAS_D = BIAS_D_DEF,
  parameter int BIAS_S = BIAS_S_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_vld,
  input  logic        stall,
  input  logic        flush,
  input  logic [2:0]  op,
  input  logic        sel,
  input  logic [1:0]  imm,
  input  logic [67:0] A,
  input  logic [67:0] B,
  output logic [67:0] res,
  output logic        res_vld,
  output logic        res_err
);

  logic [67:0] src;
  logic [67:0] seed_word;
  logic [67:0] result;
  logic        is_dbl;
  logic        is_rsq;
  logic [11:0] e_dbl, e_dbl_seed;
  logic [8:0]  e_hi, e_hi_seed;
  logic [8:0]  e_lo, e_lo_seed;
  stage_t      stg_d;

  assign src    = sel ? A : B;
  assign is_dbl = (A[67:66] == PTYPE_DBL);
  assign is_rsq = (op == OP_RSQ);
  assign e_dbl  = exp_get_dbl(B);
  assign e_hi   = exp_get_lane(B[65:33]);
  assign e_lo   = exp_get_lane(B[32:0]);

  fperm_exp_seed #(.EW(12), .BIAS(BIAS_D)) u_seed_dbl (
    .e(e_dbl), .is_rsq(is_rsq), .e_seed(e_dbl_seed)
  );
  fperm_exp_seed #(.EW(9), .BIAS(BIAS_S)) u_seed_hi (
    .e(e_hi), .is_rsq(is_rsq), .e_seed(e_hi_seed)
  );
  fperm_exp_seed #(.EW(9), .BIAS(BIAS_S)) u_seed_lo (
    .e(e_lo), .is_rsq(is_rsq), .e_seed(e_lo_seed)
  );

  // Layout comes from A's tag even though the seed is built from B.
  assign seed_word = is_dbl
    ? exp_put_dbl(B[67:66], B[64], e_dbl_seed)
    : {B[67:66], exp_put_lane(B[64], e_hi_seed), exp_put_lane(B[31], e_lo_seed)};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    result = B;
    case (op_e'(op))
      OP_MOV:   result = src;
      OP_SWAP:  result = {src[67:66], src[32:0], src[65:33]};
      OP_DUPLO: result = {src[67:66], src[32:0], src[32:0]};
      OP_DUPHI: result = {src[67:66], src[65:33], src[65:33]};
      OP_BLEND: result = {B[67:66], imm[1] ? A[65:33] : B[65:33],
                                    imm[0] ? A[32:0]  : B[32:0]};
      OP_RCP,
      OP_RSQ:   result = seed_word;
      default:  result = B;
    endcase
    stg_d.data = result;
    stg_d.vld  = in_vld;
    stg_d.err  = in_vld && (op == OP_RSVD);
  end

  for (genvar k = 0; k < LAT; k++) begin : g_stage
    stage_t q;
    stage_t q_next;

    if (k == 0) begin : g_head
      assign q_next = stg_d;
    end else begin : g_body
      assign q_next = g_stage[k-1].q;
    end

    // NOTE: state uses non-blocking assignments; the async reset clears data as well as vld.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        q <= '0;
      end else if (flush) begin
        q.vld <= 1'b0;
      end else if (!stall) begin
        q <= q_next;
      end
    end
  end

  assign res     = g_stage[LAT-1].q.data;
  assign res_vld = g_stage[LAT-1].q.vld;
  assign res_err = g_stage[LAT-1].q.err;

endmodule

// File: tb/tb_fperm_pipe.sv
// Self-checking bench for fperm_pipe: directed scenarios plus randomized traffic
// against a spec-level reference model and a latency/ordering shadow.
module tb_fperm_pipe;
  import fperm_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld, stall, flush, sel;
  logic [2:0]  op;
  logic [1:0]  imm;
  logic [67:0] A, B;
  logic [67:0] res;
  logic        res_vld, res_err;

  int n_vec = 0;
  int n_err = 0;

  logic [67:0] m_data [LAT];
  logic        m_vld  [LAT];
  logic        m_err  [LAT];

  fperm_pipe #(.LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .stall(stall), .flush(flush),
    .op(op), .sel(sel), .imm(imm), .A(A), .B(B),
    .res(res), .res_vld(res_vld), .res_err(res_err)
  );

  always #5 clk = ~clk;

  function automatic logic [67:0] rnd68();
    return 68'({$urandom(), $urandom(), $urandom()});
  endfunction

  function automatic logic [32:0] rnd33();
    return 33'({$urandom(), $urandom()});
  endfunction

  function automatic logic [67:0] mk_dbl(input logic [1:0] tag, input logic s,
                                         input logic [11:0] e, input logic [52:0] m);
    logic [67:0] w;
    w = '0;
    w[67:66] = tag; w[64] = s; w[63] = e[11]; w[65] = e[10]; w[62:53] = e[9:0];
    w[52:0] = m;
    return w;
  endfunction

  function automatic logic [67:0] mk_sngl(input logic [1:0] tag,
                                          input logic sh, input logic [8:0] eh, input logic [22:0] mh,
                                          input logic sl, input logic [8:0] el, input logic [22:0] ml);
    logic [67:0] w;
    w = '0;
    w[67:66] = tag;
    w[64] = sh; w[63] = eh[8]; w[65] = eh[7]; w[62:56] = eh[6:0]; w[55:33] = mh;
    w[31] = sl; w[30] = el[8]; w[32] = el[7]; w[29:23] = el[6:0]; w[22:0] = ml;
    return w;
  endfunction

  function automatic int seed_int(input int e, input int ew, input int bias, input bit rsq);
    int m;
    m = 1 << ew;
    if (rsq) return (((3 * bias - e + 4 * m) % (4 * m)) / 2) % m;
    return (2 * bias - e + 4 * m) % m;
  endfunction

  task automatic ref_calc(input logic [2:0] o, input logic s, input logic [1:0] im,
                          input logic [67:0] a, input logic [67:0] b,
                          output logic [67:0] r, output logic e);
    logic [67:0] srcw;
    int ed, eh, el;
    bit rsq;
    srcw = s ? a : b;
    e = 1'b0;
    rsq = (o == 3'd5);
    case (o)
      3'd0: r = srcw;
      3'd1: r = {srcw[67:66], srcw[32:0], srcw[65:33]};
      3'd2: r = {srcw[67:66], srcw[32:0], srcw[32:0]};
      3'd3: r = {srcw[67:66], srcw[65:33], srcw[65:33]};
      3'd6: r = {b[67:66], im[1] ? a[65:33] : b[65:33], im[0] ? a[32:0] : b[32:0]};
      3'd4, 3'd5: begin
        if (a[67:66] == PTYPE_DBL) begin
          ed = int'({b[63], b[65], b[62:53]});
          r = mk_dbl(b[67:66], b[64], 12'(seed_int(ed, 12, 2047, rsq)), 53'd0);
        end else begin
          eh = int'({b[63], b[65], b[62:56]});
          el = int'({b[30], b[32], b[29:23]});
          r = mk_sngl(b[67:66], b[64], 9'(seed_int(eh, 9, 255, rsq)), 23'd0,
                      b[31], 9'(seed_int(el, 9, 255, rsq)), 23'd0);
        end
      end
      default: begin r = b; e = 1'b1; end
    endcase
  endtask

  task automatic model_clear();
    for (int i = 0; i < LAT; i++) begin
      m_vld[i] = 1'b0; m_data[i] = '0; m_err[i] = 1'b0;
    end
  endtask

  // One clock: compare outputs to the shadow at negedge, then advance the shadow.
  task automatic step();
    logic [67:0] r;
    logic        e;
    @(negedge clk);
    n_vec++;
    if (res_vld !== m_vld[LAT-1]) begin
      n_err++;
      $display("FAIL model_vld t=%0t: got %b expected %b", $time, res_vld, m_vld[LAT-1]);
    end
    if (m_vld[LAT-1]) begin
      n_vec++;
      if (res !== m_data[LAT-1] || res_err !== m_err[LAT-1]) begin
        n_err++;
        $display("FAIL model_res t=%0t: got %h err %b expected %h err %b",
                 $time, res, res_err, m_data[LAT-1], m_err[LAT-1]);
      end
    end
    ref_calc(op, sel, imm, A, B, r, e);
    @(posedge clk);
    if (flush) begin
      for (int i = 0; i < LAT; i++) m_vld[i] = 1'b0;
    end else if (!stall) begin
      for (int i = LAT - 1; i > 0; i--) begin
        m_data[i] = m_data[i-1]; m_vld[i] = m_vld[i-1]; m_err[i] = m_err[i-1];
      end
      m_data[0] = r; m_vld[0] = in_vld; m_err[0] = in_vld & e;
    end
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic s, input logic [1:0] im,
                       input logic [67:0] a, input logic [67:0] b);
    op = o; sel = s; imm = im; A = a; B = b; in_vld = 1'b1;
    step();
    in_vld = 1'b0;
    repeat (LAT - 1) step();
  endtask

  task automatic test_reset();
    rst = 1'b0; in_vld = 0; stall = 0; flush = 0; op = '0; sel = 0; imm = '0; A = '0; B = '0;
    model_clear();
    #3;
    n_vec++;
    if ({res, res_vld, res_err} !== 70'b0) begin
      n_err++;
      $display("FAIL reset_init: got res %h vld %b err %b expected all zero", res, res_vld, res_err);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_rcp_dbl();
    logic [67:0] b;
    b = mk_dbl(PTYPE_DBL, 1'b1, 12'd2047, 53'(rnd68()));
    issue(3'd4, 1'b0, 2'b00, mk_dbl(PTYPE_DBL, 1'b0, 12'd5, 53'd7), b);
    n_vec++;
    if (res_vld !== 1'b1 || res !== mk_dbl(PTYPE_DBL, 1'b1, 12'd2047, 53'd0)) begin
      n_err++; $display("FAIL rcp_dbl_1p0: got %h vld %b expected %h", res, res_vld,
                        mk_dbl(PTYPE_DBL, 1'b1, 12'd2047, 53'd0));
    end
    b = mk_dbl(PTYPE_DBL, 1'b0, 12'd2048, 53'(rnd68()));
    issue(3'd4, 1'b1, 2'b00, mk_dbl(PTYPE_DBL, 1'b1, 12'd9, 53'd1), b);
    n_vec++;
    if (res !== mk_dbl(PTYPE_DBL, 1'b0, 12'd2046, 53'd0)) begin
      n_err++; $display("FAIL rcp_dbl_2048: got %h expected exp 2046", res);
    end
    b = mk_dbl(PTYPE_DBL, 1'b1, 12'd0, 53'(rnd68()));
    issue(3'd4, 1'b0, 2'b00, mk_dbl(PTYPE_DBL, 1'b0, 12'd1, 53'd0), b);
    n_vec++;
    if (res !== mk_dbl(PTYPE_DBL, 1'b1, 12'd4094, 53'd0)) begin
      n_err++; $display("FAIL rcp_dbl_zero: got %h expected exp 4094", res);
    end
  endtask

  task automatic test_seed_sngl();
    logic [67:0] a, b;
    a = mk_sngl(PTYPE_SNGL, 1'b0, 9'd1, 23'd3, 1'b1, 9'd2, 23'd4);
    b = mk_sngl(PTYPE_SNGL, 1'b0, 9'd257, 23'(rnd33()), 1'b1, 9'd255, 23'(rnd33()));
    issue(3'd5, 1'b0, 2'b00, a, b);
    n_vec++;
    if (res !== mk_sngl(PTYPE_SNGL, 1'b0, 9'd254, 23'd0, 1'b1, 9'd255, 23'd0)) begin
      n_err++; $display("FAIL rsq_sngl: got %h expected hi 254 lo 255", res);
    end
    issue(3'd4, 1'b0, 2'b00, a, b);
    n_vec++;
    if (res !== mk_sngl(PTYPE_SNGL, 1'b0, 9'd253, 23'd0, 1'b1, 9'd255, 23'd0)) begin
      n_err++; $display("FAIL rcp_sngl: got %h expected hi 253 lo 255", res);
    end
  endtask

  task automatic test_moves();
    logic [32:0] x, y, p, q;
    logic [1:0]  t;
    t = PTYPE_SNGL; x = rnd33(); y = rnd33(); p = rnd33(); q = rnd33();
    issue(3'd1, 1'b1, 2'b00, {t, x, y}, {t, p, q});
    n_vec++;
    if (res !== {t, y, x}) begin n_err++; $display("FAIL swap: got %h expected %h", res, {t, y, x}); end
    issue(3'd3, 1'b0, 2'b00, {t, x, y}, {t, p, q});
    n_vec++;
    if (res !== {t, p, p}) begin n_err++; $display("FAIL duphi: got %h expected %h", res, {t, p, p}); end
    issue(3'd6, 1'b0, 2'b10, {t, x, y}, {t, p, q});
    n_vec++;
    if (res !== {t, x, q}) begin n_err++; $display("FAIL blend: got %h expected %h", res, {t, x, q}); end
    issue(3'd2, 1'b1, 2'b00, {t, x, y}, {t, p, q});
    n_vec++;
    if (res !== {t, y, y}) begin n_err++; $display("FAIL duplo: got %h expected %h", res, {t, y, y}); end
  endtask

  task automatic test_rsvd();
    logic [67:0] b;
    b = rnd68();
    issue(3'd7, 1'b1, 2'b11, rnd68(), b);
    n_vec++;
    if (res !== b || res_err !== 1'b1 || res_vld !== 1'b1) begin
      n_err++; $display("FAIL rsvd: got %h err %b expected %h err 1", res, res_err, b);
    end
  endtask

  task automatic test_back_to_back();
    logic [67:0] snap;
    logic        snap_v;
    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(0, 7)); sel = 1'($urandom()); imm = 2'($urandom());
      A = rnd68(); B = rnd68(); in_vld = 1'b1;
      if (i == 4) begin
        stall = 1'b1;
        snap = res; snap_v = res_vld;
        for (int s = 0; s < 3; s++) begin
          step();
          n_vec++;
          if (res !== snap || res_vld !== snap_v) begin
            n_err++; $display("FAIL stall_hold: got %h/%b expected %h/%b", res, res_vld, snap, snap_v);
          end
        end
        stall = 1'b0;
      end
      step();
    end
    in_vld = 1'b0;
    repeat (LAT + 1) step();
  endtask

  task automatic test_flush();
    int cyc;
    op = 3'd0; sel = 1'b1; in_vld = 1'b1;
    A = rnd68(); step();
    A = rnd68(); step();
    in_vld = 1'b0; stall = 1'b1; flush = 1'b1;
    step();
    stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < LAT + 1; i++) begin
      n_vec++;
      if (res_vld !== 1'b0) begin n_err++; $display("FAIL flush_kill: got vld %b expected 0", res_vld); end
      step();
    end
    A = rnd68(); in_vld = 1'b1;
    step();
    in_vld = 1'b0;
    cyc = 1;
    while (res_vld !== 1'b1 && cyc < 10) begin step(); cyc++; end
    n_vec++;
    if (cyc != LAT) begin n_err++; $display("FAIL flush_latency: got %0d cycles expected %0d", cyc, LAT); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom_range(0, 7)); sel = 1'($urandom()); imm = 2'($urandom());
      A = rnd68(); B = rnd68();
      if ($urandom_range(0, 1) == 0) A[67:66] = PTYPE_DBL;
      in_vld = ($urandom_range(0, 3) != 0);
      stall  = ($urandom_range(0, 6) == 0);
      flush  = ($urandom_range(0, 30) == 0);
      step();
    end
    in_vld = 0; stall = 0; flush = 0;
    repeat (LAT + 1) step();
  endtask

  task automatic test_reset_mid();
    op = 3'd0; sel = 1'b0; in_vld = 1'b1;
    B = rnd68(); step();
    B = rnd68(); step();
    in_vld = 1'b0;
    n_vec++;
    if (res_vld !== 1'b1) begin n_err++; $display("FAIL reset_pre: got vld %b expected 1", res_vld); end
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if ({res, res_vld, res_err} !== 70'b0) begin
      n_err++; $display("FAIL reset_async: got res %h vld %b err %b expected all zero", res, res_vld, res_err);
    end
    model_clear();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    repeat (LAT + 1) step();
  endtask

  initial begin
    test_reset();
    test_rcp_dbl();
    test_seed_sngl();
    test_moves();
    test_rsvd();
    test_back_to_back();
    test_flush();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
